// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one CHUNK of the operands is resolved per stage,
// and each stage registers its chunk carry-out for the stage that follows.
module cla_pipe_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4,
    parameter int BLOCK  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam int NBLK  = CHUNK / BLOCK;

    // Handshake: a beat transfers on a rising edge where valid & ready are both high.
    // A stall (out_valid & ~out_ready) freezes every stage, bubbles included.
    logic w_stall;

    // Returns {chunk carry-out, chunk sum}. Group carries are a two-level sum of products
    // from the chunk carry-in; bits inside one BLOCK ripple from their group carry.
    function automatic logic [CHUNK:0] cla_chunk(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             ci);
        logic [CHUNK-1:0] g;
        logic [CHUNK-1:0] p;
        logic [NBLK-1:0]  gg;
        logic [NBLK-1:0]  gp;
        logic [NBLK:0]    bc;
        logic [CHUNK:0]   c;
        logic             t;
        logic             pr;
        g = x & y;
        p = x ^ y;
        for (int j = 0; j < NBLK; j++) begin
            gg[j] = 1'b0;
            gp[j] = 1'b1;
            for (int i = 0; i < BLOCK; i++) begin
                gg[j] = g[j*BLOCK+i] | (p[j*BLOCK+i] & gg[j]);
                gp[j] = gp[j] & p[j*BLOCK+i];
            end
        end
        bc[0] = ci;
        for (int j = 0; j < NBLK; j++) begin
            t = ci;
            for (int i = 0; i <= j; i++) t = t & gp[i];
            for (int i = 0; i <= j; i++) begin
                pr = gg[i];
                for (int m = i + 1; m <= j; m++) pr = pr & gp[m];
                t = t | pr;
            end
            bc[j+1] = t;
        end
        c = '0;
        for (int j = 0; j < NBLK; j++) begin
            c[j*BLOCK] = bc[j];
            for (int i = 0; i < BLOCK - 1; i++)
                c[j*BLOCK+i+1] = g[j*BLOCK+i] | (p[j*BLOCK+i] & c[j*BLOCK+i]);
        end
        c[CHUNK] = bc[NBLK];
        return {c[CHUNK], p ^ c[CHUNK-1:0]};
    endfunction

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_st
            localparam int REM = WIDTH - k * CHUNK;
            logic [REM-1:0]         w_a_i;
            logic [REM-1:0]         w_b_i;
            logic                   w_c_i;
            logic                   w_v_i;
            logic [CHUNK:0]         w_res;
            logic [(k+1)*CHUNK-1:0] w_s_nx;
            logic                   r_v;
            logic                   r_c;
            logic [(k+1)*CHUNK-1:0] r_s;

            assign w_res = cla_chunk(w_a_i[CHUNK-1:0], w_b_i[CHUNK-1:0], w_c_i);

            if (k == 0) begin : g_in
                assign w_a_i  = a;
                assign w_b_i  = sub ? ~b : b;
                assign w_c_i  = cin ^ sub;
                assign w_v_i  = in_valid;
                assign w_s_nx = w_res[CHUNK-1:0];
            end else begin : g_link
                assign w_a_i  = g_st[k-1].g_fwd.r_a;
                assign w_b_i  = g_st[k-1].g_fwd.r_b;
                assign w_c_i  = g_st[k-1].r_c;
                assign w_v_i  = g_st[k-1].r_v;
                assign w_s_nx = {w_res[CHUNK-1:0], g_st[k-1].r_s};
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v <= 1'b0;
                    r_c <= 1'b0;
                    r_s <= '0;
                end else if (!w_stall) begin
                    r_v <= w_v_i;
                    r_c <= w_res[CHUNK];
                    r_s <= w_s_nx;
                end
            end

            // Only the operand bits still to be added travel down the pipe.
            if (k < STAGES - 1) begin : g_fwd
                logic [REM-CHUNK-1:0] r_a;
                logic [REM-CHUNK-1:0] r_b;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_a <= '0;
                        r_b <= '0;
                    end else if (!w_stall) begin
                        r_a <= w_a_i[REM-1:CHUNK];
                        r_b <= w_b_i[REM-1:CHUNK];
                    end
                end
            end else begin : g_last
                // Carry into the MSB recovered as sum ^ propagate at that bit.
                logic r_cm;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_cm <= 1'b0;
                    end else if (!w_stall) begin
                        r_cm <= w_res[CHUNK-1] ^ w_a_i[CHUNK-1] ^ w_b_i[CHUNK-1];
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_st[STAGES-1].r_v;
    assign sum       = g_st[STAGES-1].r_s;
    assign cout      = g_st[STAGES-1].r_c;
    assign ovf       = g_st[STAGES-1].g_last.r_cm ^ g_st[STAGES-1].r_c;
    assign w_stall   = out_valid & ~out_ready;
    assign in_ready  = ~w_stall;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed corner cases, random streams with stalls,
// mid-flight reset, and a STAGES/BLOCK configuration sweep, all against an arithmetic model.
module tb_cla_pipe_adder;
  localparam int WIDTH  = 16;
  localparam int STAGES = 4;
  localparam int NCFG   = 6;

  function automatic int cfg_st(input int i);
    return (i < 2) ? 1 : (i < 4) ? 2 : (i == 4) ? 4 : 8;
  endfunction
  function automatic int cfg_bl(input int i);
    return (i == 1 || i == 3) ? 4 : 2;
  endfunction

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic             in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [WIDTH-1:0] a, b, sum;

  cla_pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES), .BLOCK(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  // configuration sweep instances share one stimulus
  logic                        sw_valid, sw_cin, sw_sub;
  logic [WIDTH-1:0]            sw_a, sw_b;
  logic [NCFG-1:0]             sw_iready, sw_ov, sw_cout, sw_ovf;
  logic [NCFG-1:0][WIDTH-1:0]  sw_sum;

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_sw
    cla_pipe_adder #(.WIDTH(WIDTH), .STAGES(cfg_st(gi)), .BLOCK(cfg_bl(gi))) u_sw (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_iready[gi]),
      .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub), .out_valid(sw_ov[gi]),
      .out_ready(1'b1), .sum(sw_sum[gi]), .cout(sw_cout[gi]), .ovf(sw_ovf[gi])
    );
  end

  // scoreboard state
  logic [WIDTH+1:0] exp_q[$];
  int               acc_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  int               cyc = 0, n_in = 0, n_out = 0;
  int               last_lat = -1, last_out_cyc = -10, run_len = 0, max_run = 0;
  logic [WIDTH-1:0] last_sum;
  logic             last_cout, last_ovf;
  logic             hold_pending = 1'b0;
  logic [WIDTH-1:0] hold_sum;
  logic             hold_cout, hold_ovf;

  // driver values applied on the next step
  logic             drv_valid, drv_sub, drv_cin, drv_ready;
  logic [WIDTH-1:0] drv_a, drv_b;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer add of A and the conditioned B with carry-in cin^sub.
  function automatic logic [WIDTH+1:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic s, input logic ci);
    logic [WIDTH-1:0] yy;
    logic [WIDTH:0]   t;
    logic             ov;
    yy = s ? ~y : y;
    t  = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, ci ^ s};
    ov = (x[WIDTH-1] == yy[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
    return {t[WIDTH], ov, t[WIDTH-1:0]};
  endfunction

  task automatic randomize_ops();
    drv_a   = WIDTH'($urandom_range(0, 65535));
    drv_b   = WIDTH'($urandom_range(0, 65535));
    drv_sub = 1'($urandom_range(0, 1));
    drv_cin = 1'($urandom_range(0, 1));
  endtask

  // One clock: drive after the falling edge, sample 1 ns later, before the rising edge.
  task automatic step();
    logic [WIDTH+1:0] e;
    @(negedge clk);
    in_valid = drv_valid; a = drv_a; b = drv_b; sub = drv_sub; cin = drv_cin;
    out_ready = drv_ready;
    #1;
    if (hold_pending) begin
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_sum", sum, hold_sum);
      check_eq("hold_cout", cout, hold_cout);
      check_eq("hold_ovf", ovf, hold_ovf);
    end
    hold_pending = out_valid && !out_ready;
    hold_sum = sum; hold_cout = cout; hold_ovf = ovf;
    check_eq("in_ready", in_ready, !(out_valid && !out_ready));
    if (out_valid && out_ready) begin
      check_eq("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        last_lat = cyc - acc_q.pop_front();
        check_eq("sb_sum", sum, e[WIDTH-1:0]);
        check_eq("sb_cout", cout, e[WIDTH+1]);
        check_eq("sb_ovf", ovf, e[WIDTH]);
      end
      last_sum = sum; last_cout = cout; last_ovf = ovf;
      run_len = (last_out_cyc == cyc - 1) ? run_len + 1 : 1;
      if (run_len > max_run) max_run = run_len;
      last_out_cyc = cyc;
      n_out++;
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(ref_add(a, b, sub, cin));
      acc_q.push_back(cyc);
      n_in++;
    end
    cyc++;
  endtask

  task automatic single_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s,
                           input logic ci, input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    int prev;
    int t;
    drv_valid = 1'b1; drv_a = x; drv_b = y; drv_sub = s; drv_cin = ci; drv_ready = 1'b1;
    prev = n_out;
    step();
    drv_valid = 1'b0;
    t = 0;
    while (n_out == prev && t < 20) begin
      step();
      t++;
    end
    check_eq("dir_done", n_out - prev, 1);
    check_eq("dir_latency", last_lat, STAGES);
    check_eq("dir_sum", last_sum, es);
    check_eq("dir_cout", last_cout, ec);
    check_eq("dir_ovf", last_ovf, eo);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev, in0, t;
    int sw_lat[NCFG];
    logic [WIDTH-1:0] sw_res[NCFG];

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    drv_valid = 1'b0; drv_a = '0; drv_b = '0; drv_sub = 1'b0; drv_cin = 1'b0; drv_ready = 1'b1;
    sw_valid = 1'b0; sw_a = 16'h1234; sw_b = 16'h4321; sw_cin = 1'b1; sw_sub = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_sum", sum, 0);
    check_eq("rst_cout", cout, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_in_ready", in_ready, 1);

    // directed corner cases
    single_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    single_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    single_op(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    single_op(16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0);

    // back-to-back stream at full throughput
    prev = n_out; max_run = 0; drv_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      randomize_ops();
      drv_valid = 1'b1;
      step();
    end
    drv_valid = 1'b0;
    repeat (STAGES + 2) step();
    check_eq("b2b_count", n_out - prev, 100);
    check_eq("b2b_consecutive", max_run, 100);

    // random valid / ready with stalls
    in0 = n_in; prev = n_out; t = 0;
    while (n_in - in0 < 1000 && t < 20000) begin
      randomize_ops();
      drv_valid = 1'($urandom_range(0, 1));
      drv_ready = ($urandom_range(0, 9) >= 3);
      step();
      t++;
    end
    drv_valid = 1'b0; drv_ready = 1'b1; t = 0;
    while (exp_q.size() > 0 && t < 100) begin
      step();
      t++;
    end
    repeat (STAGES + 1) step();
    check_eq("rnd_accepted", n_in - in0, 1000);
    check_eq("rnd_delivered", n_out - prev, 1000);
    check_eq("rnd_queue_empty", exp_q.size(), 0);

    // reset while results are in flight and stalled
    drv_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      randomize_ops();
      drv_valid = 1'b1;
      step();
    end
    drv_valid = 1'b0; t = 0;
    while (!out_valid && t < 20) begin
      step();
      t++;
    end
    check_eq("mid_loaded", out_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_in_ready", in_ready, 1);
    exp_q.delete(); acc_q.delete(); hold_pending = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drv_ready = 1'b1; prev = n_out;
    repeat (10) step();
    check_eq("mid_no_stale", n_out - prev, 0);
    single_op(16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

    // configuration sweep: 0x1234 + 0x4321 + 1
    for (int i = 0; i < NCFG; i++) begin
      sw_lat[i] = -1;
      sw_res[i] = '0;
    end
    @(negedge clk);
    sw_valid = 1'b1;
    for (int s = 1; s <= 12; s++) begin
      @(negedge clk);
      sw_valid = 1'b0;
      #1;
      for (int i = 0; i < NCFG; i++) begin
        if (sw_lat[i] < 0 && sw_ov[i]) begin
          sw_lat[i] = s;
          sw_res[i] = sw_sum[i];
        end
      end
    end
    for (int i = 0; i < NCFG; i++) begin
      check_eq($sformatf("sweep_lat_st%0d_bl%0d", cfg_st(i), cfg_bl(i)), sw_lat[i], cfg_st(i));
      check_eq($sformatf("sweep_sum_st%0d_bl%0d", cfg_st(i), cfg_bl(i)), sw_res[i], 16'h5556);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
